// File: rtl/long_bus_arbiter_if.sv
// long_bus_arbiter_if: request/data inputs and grant/bus outputs of the shared-bus arbiter
interface long_bus_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    Req;
   logic [NREQ*DW-1:0] WData;
   logic [NREQ-1:0]    Gnt;
   logic               BusEn;
   logic [DW-1:0]      BusData;
   logic [2:0]         Owner;
   logic               Timeout;
   modport master (output Req, WData, input Gnt, BusEn, BusData, Owner, Timeout);
   modport slave  (input Req, WData, output Gnt, BusEn, BusData, Owner, Timeout);
endinterface

// File: rtl/long_bus_arbiter.sv
// long_bus_arbiter: round-robin owner sequencer for a shared bus with zeroed turnaround gaps
module long_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 8,
   parameter int TURN     = 1,
   parameter int MAX_HOLD = 16
) (
   input logic               Clock,
   input logic               nReset,
   long_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;
   state_t            state_q;
   logic [NREQ-1:0]   gnt_q;
   logic [2:0]        owner_q, ptr_q, turn_q, sel_d, ptr_d;
   logic [7:0]        hold_q;
   logic              timeout_q, found_d, own_req;
   logic [2*NREQ-1:0] dbl_d;
   logic [DW-1:0]     data_d;
   assign dbl_d   = {bus.Req, bus.Req} >> ptr_q;
   assign own_req = |(bus.Req & gnt_q);
   assign ptr_d   = (owner_q == 3'(NREQ-1)) ? 3'd0 : owner_q + 3'd1;
   // first requester at or after the pointer, searching cyclically
   always_comb begin
      sel_d   = '0;
      found_d = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found_d && dbl_d[k]) begin
            found_d = 1'b1;
            sel_d   = 3'((4'(ptr_q) + 4'(k)) % 4'(NREQ));
         end
      end
   end
   // owner's slice onto the bus; all zeros whenever no grant is held
   always_comb begin
      data_d = '0;
      for (int i = 0; i < NREQ; i++)
         data_d |= gnt_q[i] ? bus.WData[i*DW +: DW] : '0;
   end
   // grant / hold / turnaround sequencing with registered outputs
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE:
               if (found_d) begin
                  gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << sel_d;
                  owner_q <= sel_d;
                  hold_q  <= 8'd1;
                  state_q <= S_GRANT;
               end
            S_GRANT:
               if (!own_req || hold_q == 8'(MAX_HOLD)) begin
                  gnt_q     <= '0;
                  ptr_q     <= ptr_d;
                  turn_q    <= '0;
                  timeout_q <= own_req;
                  state_q   <= S_TURN;
               end else
                  hold_q <= hold_q + 8'd1;
            default:
               if (turn_q == 3'(TURN-1))
                  state_q <= S_IDLE;
               else
                  turn_q <= turn_q + 3'd1;
         endcase
      end
   end
   assign bus.Gnt     = gnt_q;
   assign bus.BusEn   = |gnt_q;
   assign bus.BusData = data_d;
   assign bus.Owner   = owner_q;
   assign bus.Timeout = timeout_q;
endmodule
